// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer controller.
// Holds the FSM state encoding and the width of the exported STATE bus.
package timer_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUN     = 3'd2,
        HOLD    = 3'd3,
        EXPIRED = 3'd4
    } state_t;

endpackage

// File: rtl/down_counter_ld.sv
// Synchronous loadable down counter.
// Ports:
//   CLK    - clock, rising edge
//   RST    - synchronous active-high reset, clears the count
//   LD     - load LD_VAL (has priority over EN)
//   LD_VAL - value to load
//   EN     - decrement by one; saturates at zero
//   OUT    - current count
//   IS_ONE - high when OUT equals one
module down_counter_ld #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD,
    input  logic [WIDTH-1:0] LD_VAL,
    input  logic             EN,
    output logic [WIDTH-1:0] OUT,
    output logic             IS_ONE
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT <= '0;
        end else if (LD) begin
            OUT <= LD_VAL;
        end else if (EN && (OUT != '0)) begin
            OUT <= OUT - 1'b1;
        end
    end

    assign IS_ONE = (OUT == WIDTH'(1));

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: sequences a loadable down counter with
// load/start/pause/abort commands, a clock prescaler, optional auto-reload
// and a one-cycle DONE pulse on expiry.
// Ports:
//   CLK, RST  - clock (rising edge) and synchronous active-high reset
//   LOAD      - latch LOAD_VAL into the reload register and the counter
//   LOAD_VAL  - count value to load
//   START     - begin or resume counting
//   PAUSE     - freeze counting
//   ABORT     - cancel and return to IDLE (reload register kept)
//   COUNT     - current counter value
//   BUSY      - registered, high in RUN or HOLD
//   DONE      - registered one-cycle expiry pulse
//   STATE     - registered FSM state encoding
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned PRESCALE    = 4,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               LOAD,
    input  logic [WIDTH-1:0]   LOAD_VAL,
    input  logic               START,
    input  logic               PAUSE,
    input  logic               ABORT,
    output logic [WIDTH-1:0]   COUNT,
    output logic               BUSY,
    output logic               DONE,
    output logic [STATE_W-1:0] STATE
);

    localparam int unsigned    PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_t           state_q, state_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             step;
    logic             cnt_ld, cnt_en, cnt_is_one;
    logic [WIDTH-1:0] cnt_ld_val;

    down_counter_ld #(.WIDTH(WIDTH)) u_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .LD     (cnt_ld),
        .LD_VAL (cnt_ld_val),
        .EN     (cnt_en),
        .OUT    (COUNT),
        .IS_ONE (cnt_is_one)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            ps_q     <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ps_q     <= ps_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        ps_d       = ps_q;
        reload_d   = reload_q;
        done_d     = 1'b0;
        step       = 1'b0;
        cnt_ld     = 1'b0;
        cnt_ld_val = '0;
        cnt_en     = 1'b0;

        if (ABORT) begin
            state_d = IDLE;
            ps_d    = '0;
            cnt_ld  = 1'b1;
        end else if (LOAD) begin
            state_d    = ARMED;
            ps_d       = '0;
            reload_d   = LOAD_VAL;
            cnt_ld     = 1'b1;
            cnt_ld_val = LOAD_VAL;
        end else begin
            unique case (state_q)
                IDLE: ;
                ARMED: begin
                    if (START) begin
                        ps_d = '0;
                        if (COUNT == '0) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (PAUSE) state_d = HOLD;
                    else       step    = 1'b1;
                end
                // The resuming edge counts as a run cycle, so each cycle
                // spent in HOLD delays expiry by exactly one cycle.
                HOLD: begin
                    if (START) step = 1'b1;
                end
                EXPIRED: begin
                    if (START) begin
                        ps_d       = '0;
                        cnt_ld     = 1'b1;
                        cnt_ld_val = reload_q;
                        // Zero reload stays expired; suppressing the pulse
                        // right after another keeps DONE from repeating.
                        if (reload_q == '0) done_d  = ~done_q;
                        else                state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (step) begin
                state_d = RUN;
                if (ps_q == PS_LAST) begin
                    ps_d = '0;
                    if (cnt_is_one) begin
                        done_d = 1'b1;
                        if (AUTO_RELOAD) begin
                            cnt_ld     = 1'b1;
                            cnt_ld_val = reload_q;
                        end else begin
                            cnt_en  = 1'b1;
                            state_d = EXPIRED;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end else begin
                    ps_d = ps_q + 1'b1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        busy_d = (state_d == RUN) || (state_d == HOLD);
        STATE  = state_q;
        BUSY   = busy_q;
        DONE   = done_q;
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: four instances with different PRESCALE /
// AUTO_RELOAD settings share one command stream. A reference model tracks
// the remaining time in clock cycles; COUNT is derived from it by rounding up.
module tb_countdown_timer_ctrl;

    localparam int NI = 4;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_HOLD = 3, M_EXP = 4;

    logic clk;
    logic rst, load, start, pause, abort;
    logic [3:0] load_val;

    logic [3:0] cnt_o  [NI];
    logic [2:0] st_o   [NI];
    logic       busy_o [NI];
    logic       done_o [NI];

    int ps_of [NI] = '{2, 2, 3, 1};
    bit ar_of [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned PS = (g == 2) ? 3 : (g == 3) ? 1 : 2;
        localparam bit          AR = (g == 1) || (g == 3);
        countdown_timer_ctrl #(.WIDTH(4), .PRESCALE(PS), .AUTO_RELOAD(AR)) u_dut (
            .CLK      (clk),
            .RST      (rst),
            .LOAD     (load),
            .LOAD_VAL (load_val),
            .START    (start),
            .PAUSE    (pause),
            .ABORT    (abort),
            .COUNT    (cnt_o[g]),
            .BUSY     (busy_o[g]),
            .DONE     (done_o[g]),
            .STATE    (st_o[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, idx, $time, act, exp);
        end
    endtask

    // Reference model: mode, remaining cycles until the terminal tick,
    // reload value, and the DONE level for the coming cycle.
    int m_mode [NI];
    int m_rem  [NI];
    int m_rel  [NI];
    bit m_done [NI];

    task automatic model_edge(input int i, input bit r, input bit a, input bit l,
                              input int lv, input bit s, input bit p);
        bit pulse;
        bit spend;
        pulse = 1'b0;
        spend = 1'b0;
        if (r) begin
            m_mode[i] = M_IDLE; m_rem[i] = 0; m_rel[i] = 0;
        end else if (a) begin
            m_mode[i] = M_IDLE; m_rem[i] = 0;
        end else if (l) begin
            m_mode[i] = M_ARMED; m_rel[i] = lv; m_rem[i] = lv * ps_of[i];
        end else if (m_mode[i] == M_ARMED) begin
            if (s) begin
                if (m_rem[i] == 0) begin m_mode[i] = M_EXP; pulse = 1'b1; end
                else m_mode[i] = M_RUN;
            end
        end else if (m_mode[i] == M_RUN) begin
            if (p) m_mode[i] = M_HOLD;
            else   spend = 1'b1;
        end else if (m_mode[i] == M_HOLD) begin
            if (s) begin m_mode[i] = M_RUN; spend = 1'b1; end
        end else if (m_mode[i] == M_EXP) begin
            if (s) begin
                if (m_rel[i] == 0) pulse = !m_done[i];
                else begin m_mode[i] = M_RUN; m_rem[i] = m_rel[i] * ps_of[i]; end
            end
        end
        if (spend) begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
                pulse = 1'b1;
                if (ar_of[i]) m_rem[i] = m_rel[i] * ps_of[i];
                else          m_mode[i] = M_EXP;
            end
        end
        m_done[i] = pulse;
    endtask

    typedef struct packed {
        logic [NI-1:0][3:0] cnt;
        logic [NI-1:0][2:0] st;
        logic [NI-1:0]      busy;
        logic [NI-1:0]      done;
    } exp_t;

    exp_t sbq[$];

    // One clock cycle: drive commands, predict, then wait until just after the edge.
    task automatic cyc(input bit r, input bit a, input bit l, input int lv,
                       input bit s, input bit p);
        exp_t e;
        @(negedge clk);
        rst = r; abort = a; load = l; load_val = 4'(lv); start = s; pause = p;
        for (int i = 0; i < NI; i++) begin
            model_edge(i, r, a, l, lv, s, p);
            e.cnt[i]  = 4'((m_rem[i] + ps_of[i] - 1) / ps_of[i]);
            e.st[i]   = 3'(m_mode[i]);
            e.busy[i] = (m_mode[i] == M_RUN) || (m_mode[i] == M_HOLD);
            e.done[i] = m_done[i];
        end
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Advance until instance 0 shows the target count, within a cycle budget.
    task automatic run_until_a(input int target);
        for (int k = 0; k < 60; k++) begin
            if (cnt_o[0] == 4'(target)) break;
            idle();
        end
        check("reach_count", 0, 32'(cnt_o[0]), 32'(target));
    endtask

    // Monitor: compares every DUT output against the scoreboard after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int i = 0; i < NI; i++) begin
                    check("count", i, 32'(cnt_o[i]),  32'(e.cnt[i]));
                    check("state", i, 32'(st_o[i]),   32'(e.st[i]));
                    check("busy",  i, 32'(busy_o[i]), 32'(e.busy[i]));
                    check("done",  i, 32'(done_o[i]), 32'(e.done[i]));
                end
            end
        end
    end

    initial begin
        int seq2 [11] = '{5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0};
        int seq4 [13] = '{3, 3, 2, 2, 1, 1, 3, 3, 2, 2, 1, 1, 3};
        int done_at;

        rst = 1'b1; abort = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = '0;

        // Reset with random commands present
        for (int k = 0; k < 2; k++)
            cyc(1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom));
        for (int i = 0; i < NI; i++) begin
            check("rst_count", i, 32'(cnt_o[i]), 0);
            check("rst_state", i, 32'(st_o[i]),  0);
            check("rst_busy",  i, 32'(busy_o[i]), 0);
            check("rst_done",  i, 32'(done_o[i]), 0);
        end
        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        run_until_a(3);
        cyc(1, 0, 0, 0, 1, 0);
        check("midrun_rst_count", 0, 32'(cnt_o[0]), 0);
        check("midrun_rst_state", 0, 32'(st_o[0]),  0);

        // Basic countdown, PRESCALE=2
        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) idle();
            check("t2_seq",  k, 32'(cnt_o[0]),  32'(seq2[k]));
            check("t2_done", k, 32'(done_o[0]), (k == 10) ? 1 : 0);
        end
        idle();
        check("t2_expired", 0, 32'(st_o[0]), 4);
        check("t2_zero",    0, 32'(cnt_o[0]), 0);

        // Pause for 6 cycles at COUNT=8
        cyc(0, 0, 1, 9, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        done_at = -1;
        idle(); idle();
        check("t3_at8", 0, 32'(cnt_o[0]), 8);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 0, 0, 1);
            check("t3_hold_cnt",  k, 32'(cnt_o[0]),  8);
            check("t3_hold_busy", k, 32'(busy_o[0]), 1);
        end
        cyc(0, 0, 0, 0, 1, 0);
        for (int k = 10; k <= 30; k++) begin
            if (done_o[0] && done_at < 0) done_at = k - 1;
            if (done_at >= 0) break;
            idle();
        end
        check("t3_done_at", 0, 32'(done_at), 24);

        // Auto-reload on instance 1 (PRESCALE=2)
        cyc(0, 0, 1, 3, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 13; k++) begin
            if (k > 0) idle();
            check("t4_seq",  k, 32'(cnt_o[1]),  32'(seq4[k]));
            check("t4_done", k, 32'(done_o[1]), (k > 0 && k % 6 == 0) ? 1 : 0);
        end

        // Zero load, then expire and restart from EXPIRED
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("t5_zero_state", 0, 32'(st_o[0]),   4);
        check("t5_zero_done",  0, 32'(done_o[0]), 1);
        check("t5_zero_ar",    1, 32'(st_o[1]),   4);
        idle();
        check("t5_single_done", 0, 32'(done_o[0]), 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 2, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) idle();
        check("t5_exp", 0, 32'(st_o[0]), 4);
        cyc(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) idle();
            check("t5_restart", k, 32'(cnt_o[0]), 32'(seq2[k + 6]));
        end

        // Abort beats load; START ignored in IDLE
        cyc(0, 0, 1, 9, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        run_until_a(6);
        cyc(0, 1, 1, 7, 0, 0);
        check("t6_state", 0, 32'(st_o[0]),   0);
        check("t6_count", 0, 32'(cnt_o[0]),  0);
        check("t6_busy",  0, 32'(busy_o[0]), 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("t6_idle_start", 0, 32'(st_o[0]), 0);
        cyc(0, 0, 1, 4, 0, 0);
        check("t6_armed", 0, 32'(st_o[0]),  1);
        check("t6_cnt4",  0, 32'(cnt_o[0]), 4);

        // Randomized command stream
        for (int k = 0; k < 2500; k++) begin
            bit r, a, l, s, p;
            int lv;
            r  = ($urandom_range(0, 199) == 0);
            a  = ($urandom_range(0, 59) == 0);
            l  = ($urandom_range(0, 11) == 0);
            lv = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                             : int'($urandom_range(0, 15));
            s  = ($urandom_range(0, 2) == 0);
            p  = ($urandom_range(0, 9) == 0);
            cyc(r, a, l, lv, s, p);
        end

        idle();
        @(posedge clk);
        #3;
        check("sb_drain", 0, 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
